wallace_mul_arbiter: RTL and testbench

Shares one 16-bit Wallace multiplier instance among NREQ requesters. Uses round-robin arbitration with a valid/ready handshake on each request port. Operands and products are registered in a 2-stage pipeline: an operand stage, then the Wallace multiplier and a result stage. The block sits between client datapaths and the combinational Wallace core, which is instantiated unmodified inside it.

---
 rtl/wallace_mul_arbiter.sv | 152 +++++++++++++++
 tb/tb_wallace_mul_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wallace_mul_arbiter.sv
// Round-robin front end that shares one combinational 16x16 Wallace multiplier
// among NREQ valid/ready requesters through a two-stage operand/result pipeline.
`timescale 1ns/1ps

module wallace_mul16 (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [31:0] o_p
);

  // Row-wise carry-save reduction: 16 -> 11 -> 8 -> 6 -> 4 -> 3 -> 2 rows.
  function automatic logic [31:0] wallace(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] rows [16];
    logic [31:0] nxt  [16];
    int cnt;
    int ncnt;
    int grp;
    for (int i = 0; i < 16; i++) rows[i] = b[i] ? (32'(a) << i) : 32'd0;
    cnt = 16;
    for (int lvl = 0; lvl < 6; lvl++) begin
      for (int i = 0; i < 16; i++) nxt[i] = 32'd0;
      ncnt = 0;
      grp  = cnt / 3;
      for (int g = 0; g < 5; g++) begin
        if (g < grp) begin
          nxt[ncnt]     = rows[3*g] ^ rows[3*g+1] ^ rows[3*g+2];
          nxt[ncnt + 1] = ((rows[3*g] & rows[3*g+1]) | (rows[3*g] & rows[3*g+2]) |
                           (rows[3*g+1] & rows[3*g+2])) << 1;
          ncnt += 2;
        end
      end
      for (int r = 0; r < 16; r++) begin
        if (r >= 3 * grp && r < cnt) begin
          nxt[ncnt] = rows[r];
          ncnt++;
        end
      end
      rows = nxt;
      cnt  = ncnt;
    end
    return rows[0] + rows[1];
  endfunction

  assign o_p = wallace(i_a, i_b);

endmodule

module wallace_mul_arbiter #(
  parameter int NREQ = 4,
  parameter int N    = 16,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*N-1:0]    req_a,
  input  logic [NREQ*N-1:0]    req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [IDW-1:0]       resp_id,
  output logic [2*N-1:0]       resp_product,
  output logic                 busy
);

  logic           r_s1_valid;
  logic [IDW-1:0] r_s1_id;
  logic [N-1:0]   r_s1_a;
  logic [N-1:0]   r_s1_b;
  logic           r_resp_valid;
  logic [IDW-1:0] r_resp_id;
  logic [2*N-1:0] r_resp_product;
  logic [IDW-1:0] r_rr_ptr;

  logic           w_s2_free;
  logic           w_s1_adv;
  logic           w_accept_ok;
  logic           w_accept;
  logic           w_any;
  logic [IDW-1:0] w_win;
  logic [IDW-1:0] w_ptr_next;
  logic [2*N-1:0] w_product;

  assign w_s2_free   = !r_resp_valid || resp_ready;
  assign w_s1_adv    = r_s1_valid && w_s2_free;
  // Grants are masked while rst is held so they drop together with the pipeline.
  assign w_accept_ok = (!r_s1_valid || w_s1_adv) && !rst;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_any && req_valid[(int'(r_rr_ptr) + k) % NREQ]) begin
        w_any = 1'b1;
        w_win = IDW'((int'(r_rr_ptr) + k) % NREQ);
      end
    end
  end

  assign req_ready  = (w_any && w_accept_ok) ? (NREQ'(1) << w_win) : '0;
  assign w_accept   = |(req_valid & req_ready);
  assign w_ptr_next = (w_win == IDW'(NREQ - 1)) ? '0 : w_win + IDW'(1);

  wallace_mul16 u_core (
    .i_a (r_s1_a),
    .i_b (r_s1_b),
    .o_p (w_product)
  );

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values and the order of statements inside the block is irrelevant.
  // NOTE: operand and product registers are reset as well, because their
  // values are visible on resp_id/resp_product straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid     <= 1'b0;
      r_s1_id        <= '0;
      r_s1_a         <= '0;
      r_s1_b         <= '0;
      r_resp_valid   <= 1'b0;
      r_resp_id      <= '0;
      r_resp_product <= '0;
      r_rr_ptr       <= '0;
    end else begin
      if (w_accept) begin
        r_s1_valid <= 1'b1;
        r_s1_id    <= w_win;
        r_s1_a     <= req_a[w_win*N +: N];
        r_s1_b     <= req_b[w_win*N +: N];
        r_rr_ptr   <= w_ptr_next;
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end

      if (w_s1_adv) begin
        r_resp_valid   <= 1'b1;
        r_resp_id      <= r_s1_id;
        r_resp_product <= w_product;
      end else if (r_resp_valid && resp_ready) begin
        r_resp_valid <= 1'b0;
      end
    end
  end

  assign resp_valid   = r_resp_valid;
  assign resp_id      = r_resp_id;
  assign resp_product = r_resp_product;
  assign busy         = r_s1_valid || r_resp_valid;

endmodule

// File: tb/tb_wallace_mul_arbiter.sv
// Scoreboarded bench for wallace_mul_arbiter: a cycle model predicts grants and
// pushes expected {id, A*B}; an independent monitor pops on every response.
`timescale 1ns/1ps

module tb_wallace_mul_arbiter;

  localparam int NREQ = 4;
  localparam int N    = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic              resp_valid;
  logic              resp_ready;
  logic [1:0]        resp_id;
  logic [2*N-1:0]    resp_product;
  logic              busy;

  wallace_mul_arbiter #(.NREQ(NREQ), .N(N), .IDW(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_id      (resp_id),
    .resp_product (resp_product),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] p;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    else pass_cnt++;
  endtask

  // Cycle model of arbitration and pipeline occupancy, evaluated mid-cycle.
  int          m_ptr;
  bit          m_s1v, m_s2v, m_adv, m_ok;
  int          m_win;
  logic [3:0]  m_rdy;
  int          m_wait [NREQ];
  int          max_wait = 0;

  always @(negedge clk) begin
    if (rst) begin
      m_ptr = 0;
      m_s1v = 1'b0;
      m_s2v = 1'b0;
      sb.delete();
      for (int i = 0; i < NREQ; i++) m_wait[i] = 0;
    end else begin
      m_adv = m_s1v && (!m_s2v || resp_ready);
      m_ok  = !m_s1v || m_adv;
      m_win = -1;
      for (int k = 0; k < NREQ; k++)
        if (m_win < 0 && req_valid[(m_ptr + k) % NREQ]) m_win = (m_ptr + k) % NREQ;
      m_rdy = (m_ok && m_win >= 0) ? 4'(1 << m_win) : 4'b0;
      check("req_ready", 64'(req_ready), 64'(m_rdy));
      check("resp_valid", 64'(resp_valid), 64'(m_s2v));
      check("busy", 64'(busy), 64'(m_s1v || m_s2v));
      if (m_rdy != 4'b0) begin
        sb.push_back('{id: 2'(m_win),
                       p: 32'(req_a[m_win*N +: N]) * 32'(req_b[m_win*N +: N])});
        for (int i = 0; i < NREQ; i++) begin
          if (i == m_win || !req_valid[i]) m_wait[i] = 0;
          else m_wait[i]++;
          if (m_wait[i] > max_wait) max_wait = m_wait[i];
        end
        m_ptr = (m_win + 1) % NREQ;
      end
      if (m_adv) m_s2v = 1'b1;
      else if (m_s2v && resp_ready) m_s2v = 1'b0;
      if (m_rdy != 4'b0) m_s1v = 1'b1;
      else if (m_adv) m_s1v = 1'b0;
    end
  end

  // Response monitor: FIFO order, id, product and hold stability.
  exp_t        mon_e;
  bit          hold = 1'b0;
  logic [1:0]  held_id;
  logic [31:0] held_p;

  always @(negedge clk) begin
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("hold_product", 64'(resp_product), 64'(held_p));
        check("hold_id", 64'(resp_id), 64'(held_id));
      end
      if (resp_valid && resp_ready) begin
        if (sb.size() == 0) begin
          check("resp_spurious", 64'(1), 64'(0));
        end else begin
          mon_e = sb.pop_front();
          check("resp_id", 64'(resp_id), 64'(mon_e.id));
          check("resp_product", 64'(resp_product), 64'(mon_e.p));
        end
      end
      hold    = resp_valid && !resp_ready;
      held_id = resp_id;
      held_p  = resp_product;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[i*N +: N] = a;
    req_b[i*N +: N] = b;
  endtask

  task automatic idle(input int n);
    req_valid  = '0;
    resp_ready = 1'b1;
    repeat (n) step();
  endtask

  logic [3:0] exp_grants [6];

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b1;
    #2;
    check("rst_resp_valid", 64'(resp_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_resp_id", 64'(resp_id), 64'(0));
    check("rst_resp_product", 64'(resp_product), 64'(0));
    check("rst_req_ready", 64'(req_ready), 64'(0));
    step();
    step();
    rst = 1'b0;

    // Single request from requester 2: 3*5 two cycles after the grant.
    set_req(2, 16'd3, 16'd5);
    req_valid = 4'b0100;
    @(negedge clk);
    check("t1_grant", 64'(req_ready), 64'(4'b0100));
    step();
    req_valid = '0;
    step();
    @(negedge clk);
    check("t1_resp_valid", 64'(resp_valid), 64'(1));
    check("t1_resp_id", 64'(resp_id), 64'(2));
    check("t1_resp_product", 64'(resp_product), 64'(15));

    // All valid: pointer sits at 3, then the rotation 0,1,2,3,0.
    step();
    for (int i = 0; i < NREQ; i++) set_req(i, 16'(i + 1), 16'd10);
    req_valid = 4'hF;
    exp_grants[0] = 4'b1000; exp_grants[1] = 4'b0001; exp_grants[2] = 4'b0010;
    exp_grants[3] = 4'b0100; exp_grants[4] = 4'b1000; exp_grants[5] = 4'b0001;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      check("t2_grant", 64'(req_ready), 64'(exp_grants[j]));
      step();
    end

    // Backpressure for 5 cycles with everyone still requesting.
    resp_ready = 1'b0;
    repeat (5) step();
    @(negedge clk);
    check("t3_stalled_ready", 64'(req_ready), 64'(0));
    step();
    resp_ready = 1'b1;
    repeat (8) step();
    idle(4);

    // Extreme operands.
    set_req(0, 16'hFFFF, 16'hFFFF);
    req_valid = 4'b0001;
    step();
    set_req(1, 16'h0000, 16'hFFFF);
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    @(negedge clk);
    check("t4_max_product", 64'(resp_product), 64'(32'hFFFE0001));
    step();
    @(negedge clk);
    check("t4_zero_product", 64'(resp_product), 64'(0));
    check("t4_zero_id", 64'(resp_id), 64'(1));
    idle(3);

    // Reset while both stages hold data.
    for (int i = 0; i < NREQ; i++) set_req(i, 16'(100 + i), 16'(7 + i));
    req_valid  = 4'hF;
    resp_ready = 1'b0;
    repeat (3) step();
    @(negedge clk);
    check("t5_busy_before", 64'(busy), 64'(1));
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("t5_rst_resp_valid", 64'(resp_valid), 64'(0));
    check("t5_rst_busy", 64'(busy), 64'(0));
    check("t5_rst_req_ready", 64'(req_ready), 64'(0));
    step();
    rst        = 1'b0;
    req_valid  = 4'b1010;
    resp_ready = 1'b1;
    @(negedge clk);
    check("t5_first_grant", 64'(req_ready), 64'(4'b0010));
    step();
    idle(4);

    // Random soak: valids may drop without a grant, consumer stalls at random.
    for (int c = 0; c < 3000; c++) begin
      req_valid  = 4'($urandom);
      req_a      = {$urandom, $urandom};
      req_b      = {$urandom, $urandom};
      resp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    idle(6);

    check("drain_empty", 64'(sb.size()), 64'(0));
    check("no_starvation", 64'(max_wait < NREQ), 64'(1));
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
